synth_multi_port_memory: RTL and testbench
==========================================

// Module: synth_multi_port_memory
// PURPOSE
//  Parametrised successor to the dual-port synthesizable MIPS memory. Split I/D
//  address spaces (I at `I_START_ADDRESS in addr[31:20], D elsewhere from 0x0000_0000).
//  Adds NUM_PORTS ports, byte enables, req/valid handshake, configurable read latency,
//  sticky error detection and an optional post-reset DMEM zero-scrub FSM.
//  Sits between the pipelined CPU core (fetch/mem stages) and debug/IO masters.
// PARAMETERS
//  N              32    data/address width (fixed 32; byte enables assume 4 bytes)
//  NUM_PORTS      2     number of independent ports, 1..4
//  I_LENGTH       512   IMEM depth in words; I_WIDTH = $clog2(I_LENGTH)
//  D_LENGTH       1024  DMEM depth in words; D_WIDTH = $clog2(D_LENGTH), D_WIDTH+2 <= 20
//  RD_LAT         1     read latency in cycles from accepted req to valid, 1 or 2
//  SCRUB_ON_RESET 0     1: zero every DMEM word after reset before accepting requests
// PORTS
//  clk     in   1            clock, all logic on posedge
//  rstb    in   1            synchronous reset, active-high
//  req     in   NUM_PORTS    per-port access request
//  wr_ena  in   NUM_PORTS    per-port write (valid only with req)
//  be      in   4*NUM_PORTS  per-port byte enables, bit 0 = din[7:0]
//  addr    in   N*NUM_PORTS  per-port byte address, port p at [N*p +: N]
//  din     in   N*NUM_PORTS  per-port write data
//  dout    out  N*NUM_PORTS  per-port read data
//  valid   out  NUM_PORTS    dout of port p holds result of an accepted req
//  busy    out  1            scrub in progress; requests ignored
//  error   out  1            sticky error flag
// BEHAVIOUR
//  Reset (rstb=1 at posedge): valid=0, dout=0, error=0, pipeline flushed, scrub counter=0;
//   busy=1 if SCRUB_ON_RESET else 0. Memory contents not touched by reset itself.
//  Scrub FSM: IDLE, SCRUB. Leaving reset with SCRUB_ON_RESET=1 -> SCRUB; one DMEM word
//   zeroed per cycle, addr 0..D_LENGTH-1; after last word -> IDLE, busy=0 next cycle.
//   Total busy = D_LENGTH cycles. Reset mid-scrub restarts at word 0. IMEM never scrubbed.
//  Accept: req[p] & ~busy. No backpressure; every accepted req completes.
//  Decode: region I if addr[31:20]==`I_START_ADDRESS, else D. Physical word = addr[W+1:2].
//  Read: every accepted req (read or write) returns read-first (old) word on dout[p];
//   valid[p] pulses exactly RD_LAT cycles after the accept edge, 1 cycle per req.
//   Back-to-back reqs give back-to-back valids. dout holds last value when valid=0.
//  Write: if wr_ena[p], bytes with be=1 updated at accept edge; be=0 -> no memory change.
//  Out-of-range: I region with addr[19:I_WIDTH+2]!=0, or D region with
//   addr[31:D_WIDTH+2]!=0 -> write suppressed, returned dout=0, valid still asserted, error set.
//  Misaligned (addr[1:0]!=0): access proceeds on truncated word, error set.
//  Same-cycle collisions (same region, same physical word):
//   - write/write: highest-index port's enabled bytes win per byte; error set.
//   - read vs write: reader gets old data; no error.
//  error: set the cycle after any error condition; cleared only by reset.
//  Region select for dout muxing is pipelined with data (registered per stage, RD_LAT deep).
// TESTING
//  1 rstb pulse, SCRUB_ON_RESET=1, D_LENGTH=1024 -> busy high 1024 cycles, DMEM all 0, req ignored.
//  2 P0 write 0xDEADBEEF @0x10 be=4'b0011, then read -> old upper, dout=0x0000BEEF if preloaded 0.
//  3 RD_LAT=2, P0 read @`I_START_ADDRESS<<20|0x4 every cycle x4 -> 4 valids starting cycle+2.
//  4 P0,P1 write @0x20 same cycle, din 0x11111111/0x22222222 be=F -> mem 0x22222222, error=1.
//  5 P1 read @0x0000_2000 (D_LENGTH=1024) -> valid, dout=0, no write, error=1 until rstb.
//  6 rstb mid-scrub at word 500 -> scrub restarts at 0, busy lasts full 1024 cycles again.

Source files
------------

// File: rtl/synth_multi_port_memory.sv
// Multi-port split I/D word memory with byte enables, read-first returns, sticky error flag
// and an optional post-reset DMEM zero-scrub; every accepted request returns after RD_LAT cycles.
`ifndef I_START_ADDRESS
`define I_START_ADDRESS 12'h004
`endif

module synth_multi_port_memory #(
  parameter int N              = 32,
  parameter int NUM_PORTS      = 2,
  parameter int I_LENGTH       = 512,
  parameter int D_LENGTH       = 1024,
  parameter int RD_LAT         = 1,
  parameter bit SCRUB_ON_RESET = 1'b0
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic [NUM_PORTS-1:0]   req,
  input  logic [NUM_PORTS-1:0]   wr_ena,
  input  logic [4*NUM_PORTS-1:0] be,
  input  logic [N*NUM_PORTS-1:0] addr,
  input  logic [N*NUM_PORTS-1:0] din,
  output logic [N*NUM_PORTS-1:0] dout,
  output logic [NUM_PORTS-1:0]   valid,
  output logic                   busy,
  output logic                   error
);

  localparam int I_WIDTH = $clog2(I_LENGTH);
  localparam int D_WIDTH = $clog2(D_LENGTH);

  typedef enum logic {IDLE, SCRUB} state_t;

  state_t               state_q, state_d;
  logic [D_WIDTH-1:0]   scrub_cnt, scrub_cnt_d;

  logic [N-1:0]         imem [I_LENGTH];
  logic [N-1:0]         dmem [D_LENGTH];

  logic [NUM_PORTS-1:0] is_i, oor, misal, acc, acc_wr;
  logic [I_WIDTH-1:0]   i_idx [NUM_PORTS];
  logic [D_WIDTH-1:0]   d_idx [NUM_PORTS];
  logic                 err_any;

  logic [NUM_PORTS-1:0] s1_v, s1_sel, s1_oor;
  logic [N-1:0]         s1_i [NUM_PORTS];
  logic [N-1:0]         s1_d [NUM_PORTS];
  logic [N-1:0]         dout_q [NUM_PORTS];

  assign busy = (state_q == SCRUB);

  for (genvar g = 0; g < NUM_PORTS; g++) begin : gen_port
    assign is_i[g]   = (addr[N*g+20 +: 12] == `I_START_ADDRESS);
    assign i_idx[g]  = addr[N*g+2 +: I_WIDTH];
    assign d_idx[g]  = addr[N*g+2 +: D_WIDTH];
    assign misal[g]  = (addr[N*g +: 2] != 2'b00);
    assign oor[g]    = is_i[g] ? (addr[N*g+19 : N*g+I_WIDTH+2] != '0)
                               : (addr[N*g+N-1 : N*g+D_WIDTH+2] != '0);
    assign acc[g]    = req[g] & ~busy & ~rstb;
    assign acc_wr[g] = acc[g] & wr_ena[g] & ~oor[g];
    assign dout[N*g +: N] = dout_q[g];
  end

  // Error sources: bad range, misalignment, and two writes landing on the same word.
  always_comb begin
    err_any = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (acc[p] && (oor[p] || misal[p])) err_any = 1'b1;
      for (int q = p + 1; q < NUM_PORTS; q++) begin
        if (acc_wr[p] && acc_wr[q] && (is_i[p] == is_i[q]) &&
            (is_i[p] ? (i_idx[p] == i_idx[q]) : (d_idx[p] == d_idx[q])))
          err_any = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    scrub_cnt_d = scrub_cnt;
    case (state_q)
      SCRUB: begin
        if (scrub_cnt == D_WIDTH'(D_LENGTH - 1)) begin
          state_d     = IDLE;
          scrub_cnt_d = '0;
        end else begin
          scrub_cnt_d = scrub_cnt + D_WIDTH'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstb) begin
      state_q   <= SCRUB_ON_RESET ? SCRUB : IDLE;
      scrub_cnt <= '0;
    end else begin
      state_q   <= state_d;
      scrub_cnt <= scrub_cnt_d;
    end
  end

  // Later ports overwrite earlier ones, so the highest-index port wins each byte.
  always_ff @(posedge clk) begin
    if (busy && !rstb) dmem[scrub_cnt] <= '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (acc_wr[p]) begin
        for (int b = 0; b < 4; b++) begin
          if (be[4*p+b]) begin
            if (is_i[p]) imem[i_idx[p]][8*b +: 8] <= din[N*p+8*b +: 8];
            else         dmem[d_idx[p]][8*b +: 8] <= din[N*p+8*b +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rstb) begin
      s1_v  <= '0;
      valid <= '0;
      error <= 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) dout_q[p] <= '0;
    end else begin
      error <= error | err_any;
      for (int p = 0; p < NUM_PORTS; p++) begin
        s1_v[p] <= acc[p];
        if (acc[p]) begin
          s1_i[p]   <= imem[i_idx[p]];
          s1_d[p]   <= dmem[d_idx[p]];
          s1_sel[p] <= is_i[p];
          s1_oor[p] <= oor[p];
        end
        if (RD_LAT == 1) begin
          valid[p] <= acc[p];
          if (acc[p])
            dout_q[p] <= oor[p] ? '0 : (is_i[p] ? imem[i_idx[p]] : dmem[d_idx[p]]);
        end else begin
          valid[p] <= s1_v[p];
          if (s1_v[p])
            dout_q[p] <= s1_oor[p] ? '0 : (s1_sel[p] ? s1_i[p] : s1_d[p]);
        end
      end
    end
  end

endmodule

// File: tb/tb_synth_multi_port_memory.sv
// Scoreboarded bench: stimulus pushes hand-computed returns, a negedge monitor pops on each valid.
`ifndef I_START_ADDRESS
`define I_START_ADDRESS 12'h004
`endif

module tb_synth_multi_port_memory;
  localparam int N      = 32;
  localparam int NP     = 2;
  localparam int RD_LAT = 2;

  logic            clk = 1'b0;
  logic            rstb = 1'b1;
  logic [NP-1:0]   req = '0, wr_ena = '0;
  logic [4*NP-1:0] be = '0;
  logic [N*NP-1:0] addr = '0, din = '0;
  logic [N*NP-1:0] dout;
  logic [NP-1:0]   valid;
  logic            busy, error;

  synth_multi_port_memory #(
    .N(N), .NUM_PORTS(NP), .I_LENGTH(512), .D_LENGTH(1024),
    .RD_LAT(RD_LAT), .SCRUB_ON_RESET(1'b1)
  ) dut (
    .clk(clk), .rstb(rstb), .req(req), .wr_ena(wr_ena), .be(be),
    .addr(addr), .din(din), .dout(dout), .valid(valid), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit          care;
    logic [31:0] d;
    int          c;
    string       nm;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  task automatic push(input int p, input bit care, input logic [31:0] d, input string nm);
    exp_t e;
    e.care = care;
    e.d    = d;
    e.c    = cyc + RD_LAT;
    e.nm   = nm;
    if (p == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic issue(input int p, input bit wr, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d);
    req[p]          = 1'b1;
    wr_ena[p]       = wr;
    be[4*p +: 4]    = b;
    addr[32*p +: 32] = a;
    din[32*p +: 32]  = d;
  endtask

  task automatic clear_in;
    req = '0; wr_ena = '0; be = '0; addr = '0; din = '0;
  endtask

  task automatic step;
    @(posedge clk); #1;
    clear_in();
  endtask

  // Counts negedges with busy high; optionally injects a write while scrubbing.
  task automatic count_busy(input int inject_at, output int n);
    n = 0;
    forever begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (n == inject_at) issue(0, 1'b1, 4'hF, 32'h10, 32'hFFFF_FFFF);
      if (n == inject_at + 1) clear_in();
      if (n > 3000) break;
    end
  endtask

  always @(negedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (valid[p] === 1'b1) begin
        exp_t e;
        bit   have;
        have = (p == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (!have) begin
          check($sformatf("spurious_valid_p%0d", p), {31'b0, valid[p]}, 32'h0);
        end else begin
          if (p == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          check($sformatf("%s_cycle", e.nm), 32'(cyc), 32'(e.c));
          if (e.care) check($sformatf("%s_dout", e.nm), dout[32*p +: 32], e.d);
        end
      end
    end
  end

  initial begin
    int          n;
    logic [31:0] ia;
    ia = {`I_START_ADDRESS, 20'h00004};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {30'b0, valid}, 32'h0);
    check("rst_dout0", dout[31:0], 32'h0);
    check("rst_dout1", dout[63:32], 32'h0);
    check("rst_error", {31'b0, error}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h1);

    @(posedge clk); #1;
    rstb = 1'b0;
    count_busy(1020, n);
    check("scrub_busy_cycles", 32'(n), 32'd1024);

    // Byte-enabled write returns the scrubbed old word; the ignored write must not show
    @(posedge clk); #1;
    issue(0, 1'b1, 4'b0011, 32'h10, 32'hDEAD_BEEF); push(0, 1'b1, 32'h0, "wr_be"); step();
    issue(0, 1'b0, 4'hF, 32'h10, 32'h0); push(0, 1'b1, 32'h0000_BEEF, "rd_be"); step();
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("hold_valid", {30'b0, valid}, 32'h0);
    check("hold_dout", dout[31:0], 32'h0000_BEEF);

    // IMEM: the first write returns uninitialised data, then four back-to-back reads
    @(posedge clk); #1;
    issue(0, 1'b1, 4'hF, ia, 32'hA5A5_0004); push(0, 1'b0, 32'h0, "imem_wr"); step();
    for (int i = 0; i < 4; i++) begin
      issue(0, 1'b0, 4'hF, ia, 32'h0);
      push(0, 1'b1, 32'hA5A5_0004, $sformatf("imem_rd%0d", i));
      step();
    end

    // Same-word read vs write: reader sees old data, no error
    issue(0, 1'b1, 4'hF, 32'h30, 32'h1234_5678); push(0, 1'b1, 32'h0, "rw_wr");
    issue(1, 1'b0, 4'hF, 32'h30, 32'h0);         push(1, 1'b1, 32'h0, "rw_rd");
    step();
    issue(1, 1'b0, 4'hF, 32'h30, 32'h0); push(1, 1'b1, 32'h1234_5678, "rw_after"); step();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("no_error", {31'b0, error}, 32'h0);

    // Write/write collision: port 1 wins, error raised
    @(posedge clk); #1;
    issue(0, 1'b1, 4'hF, 32'h20, 32'h1111_1111); push(0, 1'b1, 32'h0, "ww_p0");
    issue(1, 1'b1, 4'hF, 32'h20, 32'h2222_2222); push(1, 1'b1, 32'h0, "ww_p1");
    step();
    issue(0, 1'b0, 4'hF, 32'h20, 32'h0); push(0, 1'b1, 32'h2222_2222, "ww_rd"); step();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("ww_error", {31'b0, error}, 32'h1);

    // Reset, then reset again 500 cycles into the scrub
    @(posedge clk); #1;
    rstb = 1'b1;
    @(posedge clk); #1;
    rstb = 1'b0;
    repeat (500) @(negedge clk);
    check("mid_scrub_busy", {31'b0, busy}, 32'h1);
    @(posedge clk); #1;
    rstb = 1'b1;
    @(posedge clk); #1;
    rstb = 1'b0;
    @(negedge clk);
    check("error_cleared", {31'b0, error}, 32'h0);
    count_busy(-10, n);
    check("rescrub_busy_cycles", 32'(n + 1), 32'd1024);

    // Rescrub zeroed the earlier write; out-of-range access returns 0 and does not alias
    @(posedge clk); #1;
    issue(0, 1'b0, 4'hF, 32'h10, 32'h0); push(0, 1'b1, 32'h0, "rescrub_rd"); step();
    issue(1, 1'b1, 4'hF, 32'h2000, 32'hCAFE_F00D); push(1, 1'b1, 32'h0, "oor"); step();
    issue(0, 1'b0, 4'hF, 32'h0, 32'h0); push(0, 1'b1, 32'h0, "oor_alias"); step();
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("oor_error", {31'b0, error}, 32'h1);
    check("q0_drained", 32'(q0.size()), 32'h0);
    check("q1_drained", 32'(q1.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
